// File: rtl/seq_pkg.sv
// Shared types and constants for the seq_control command sequencer.
package seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_SHIFT = 3'd2,
    ST_READ  = 3'd3,
    ST_ERROR = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TX_IDLE      = 2'd0,
    TX_WAIT_RISE = 2'd1,
    TX_WAIT_FALL = 2'd2
  } tx_phase_t;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_FULL     = 2'b11;

  localparam logic [7:0] DEF_CMD_LOAD  = 8'hFF;
  localparam logic [7:0] DEF_CMD_SHIFT = 8'h7F;
  localparam logic [7:0] DEF_CMD_READ  = 8'h7E;
  localparam logic [7:0] DEF_CMD_END   = 8'hFE;
  localparam logic [7:0] DEF_CMD_CLR   = 8'h00;

endpackage

// File: rtl/seq_watchdog.sv
// Loadable down-counter; expired is high once LIMIT enabled cycles have elapsed since the last load.
module seq_watchdog #(
  parameter int unsigned LIMIT = 1000000
) (
  input  logic clk_100,
  input  logic Reset,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] RELOAD = W'(LIMIT - 1);

  logic [W-1:0] count_reg;

  always_ff @(posedge clk_100) begin
    if (Reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= RELOAD;
    end else if (en && count_reg != '0) begin
      count_reg <= count_reg - W'(1);
    end
  end

  assign expired = (count_reg == '0);

endmodule

// File: rtl/seq_control.sv
// UART-driven sequencer: LOAD bytes into FIFO1, SHIFT them into FIFO2, READ them out to the UART.
// Define SEQ_TIMEOUT_EN to add an idle-cycle watchdog on LOAD (err_code 10).
module seq_control
  import seq_pkg::*;
#(
  parameter logic [7:0]  CMD_LOAD    = DEF_CMD_LOAD,
  parameter logic [7:0]  CMD_SHIFT   = DEF_CMD_SHIFT,
  parameter logic [7:0]  CMD_READ    = DEF_CMD_READ,
  parameter logic [7:0]  CMD_END     = DEF_CMD_END,
  parameter logic [7:0]  CMD_CLR     = DEF_CMD_CLR,
  parameter int unsigned MAX_BYTES   = 256,
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic        clk_100,
  input  logic        Reset,
  input  logic [7:0]  rx_byte,
  input  logic        rx_ready,
  input  logic        auto_mode,
  output logic        load_wr_en,
  input  logic        load_wr_ack,
  input  logic        load_full,
  input  logic        load_empty,
  output logic        shift_rd_en,
  output logic        cap_wr_en,
  input  logic        cap_empty,
  output logic        cap_rd_en,
  input  logic        cap_rd_ack,
  input  logic        tx_busy,
  output logic        tx_en,
  output logic [15:0] load_count,
  output logic [2:0]  state_o,
  output logic        err,
  output logic [1:0]  err_code
);

  localparam logic [15:0] MAX_COUNT = 16'(MAX_BYTES);

  state_t      state_reg;
  tx_phase_t   tx_phase_reg;
  logic        load_wr_en_reg, wr_second_reg, hold_valid_reg, end_pending_reg;
  logic        shift_rd_en_reg, cap_wr_en_reg, cap_rd_en_reg, tx_en_reg, rd_pending_reg;
  logic [15:0] load_count_reg;
  logic        err_reg;
  logic [1:0]  err_code_reg;

  logic       rx_data, rx_end, timeout_hit;
  logic [1:0] load_err;

  assign rx_data = rx_ready && (rx_byte != CMD_END);
  assign rx_end  = rx_ready && (rx_byte == CMD_END);

`ifdef SEQ_TIMEOUT_EN
  logic wd_load;
  assign wd_load = rx_ready && ((state_reg == ST_LOAD) ||
                                (state_reg == ST_IDLE && rx_byte == CMD_LOAD));
  seq_watchdog #(.LIMIT(TIMEOUT_CYC)) u_watchdog (
    .clk_100 (clk_100),
    .Reset   (Reset),
    .load    (wd_load),
    .en      (state_reg == ST_LOAD),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // A byte is dropped if the count is exhausted or the holding register is already occupied.
  always_comb begin
    load_err = ERR_NONE;
    if (rx_data && (load_count_reg == MAX_COUNT || hold_valid_reg)) load_err = ERR_OVERFLOW;
    else if (rx_data && load_full) load_err = ERR_FULL;
    else if (timeout_hit) load_err = ERR_TIMEOUT;
  end

  always_ff @(posedge clk_100) begin
    if (Reset) begin
      state_reg       <= ST_IDLE;
      tx_phase_reg    <= TX_IDLE;
      load_wr_en_reg  <= 1'b0;
      wr_second_reg   <= 1'b0;
      hold_valid_reg  <= 1'b0;
      end_pending_reg <= 1'b0;
      shift_rd_en_reg <= 1'b0;
      cap_wr_en_reg   <= 1'b0;
      cap_rd_en_reg   <= 1'b0;
      tx_en_reg       <= 1'b0;
      rd_pending_reg  <= 1'b0;
      load_count_reg  <= '0;
      err_reg         <= 1'b0;
      err_code_reg    <= ERR_NONE;
    end else begin
      shift_rd_en_reg <= 1'b0;
      cap_wr_en_reg   <= 1'b0;
      cap_rd_en_reg   <= 1'b0;
      tx_en_reg       <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (rx_ready) begin
            if (rx_byte == CMD_LOAD) begin
              state_reg      <= ST_LOAD;
              load_count_reg <= '0;
            end else if (rx_byte == CMD_SHIFT) begin
              state_reg <= ST_SHIFT;
            end else if (rx_byte == CMD_READ) begin
              state_reg <= ST_READ;
            end
          end
        end
        ST_LOAD: begin
          if (load_err != ERR_NONE) begin
            state_reg       <= ST_ERROR;
            err_reg         <= 1'b1;
            err_code_reg    <= load_err;
            load_wr_en_reg  <= 1'b0;
            wr_second_reg   <= 1'b0;
            hold_valid_reg  <= 1'b0;
            end_pending_reg <= 1'b0;
          end else begin
            // Write strobe ends on ack or after its second cycle; a held byte follows after a gap.
            if (load_wr_en_reg) begin
              if (load_wr_ack || wr_second_reg) begin
                load_wr_en_reg <= 1'b0;
                wr_second_reg  <= 1'b0;
              end else begin
                wr_second_reg <= 1'b1;
              end
            end else if (hold_valid_reg) begin
              load_wr_en_reg <= 1'b1;
              hold_valid_reg <= 1'b0;
            end
            if (rx_data) begin
              load_count_reg <= load_count_reg + 16'd1;
              if (load_wr_en_reg) hold_valid_reg <= 1'b1;
              else                load_wr_en_reg <= 1'b1;
            end
            // CMD_END waits for any outstanding write before leaving.
            if ((rx_end || end_pending_reg) && !load_wr_en_reg && !hold_valid_reg) begin
              end_pending_reg <= 1'b0;
              state_reg       <= auto_mode ? ST_SHIFT : ST_IDLE;
            end else if (rx_end) begin
              end_pending_reg <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          shift_rd_en_reg <= !load_empty;
          cap_wr_en_reg   <= shift_rd_en_reg;
          if (load_empty && !shift_rd_en_reg) state_reg <= auto_mode ? ST_READ : ST_IDLE;
        end
        ST_READ: begin
          if (rd_pending_reg) begin
            if (cap_rd_ack) begin
              tx_en_reg      <= 1'b1;
              rd_pending_reg <= 1'b0;
              tx_phase_reg   <= TX_WAIT_RISE;
            end
          end else if (tx_phase_reg == TX_WAIT_RISE) begin
            if (tx_busy) tx_phase_reg <= TX_WAIT_FALL;
          end else if (tx_phase_reg == TX_WAIT_FALL) begin
            if (!tx_busy) tx_phase_reg <= TX_IDLE;
          end else if (!tx_busy) begin
            if (!cap_empty) begin
              cap_rd_en_reg  <= 1'b1;
              rd_pending_reg <= 1'b1;
            end else begin
              state_reg <= ST_IDLE;
            end
          end
        end
        ST_ERROR: begin
          if (rx_ready && rx_byte == CMD_CLR) begin
            state_reg    <= ST_IDLE;
            err_reg      <= 1'b0;
            err_code_reg <= ERR_NONE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign load_wr_en  = load_wr_en_reg;
  assign shift_rd_en = shift_rd_en_reg;
  assign cap_wr_en   = cap_wr_en_reg;
  assign cap_rd_en   = cap_rd_en_reg;
  assign tx_en       = tx_en_reg;
  assign load_count  = load_count_reg;
  assign state_o     = state_reg;
  assign err         = err_reg;
  assign err_code    = err_code_reg;

endmodule

// File: tb/tb_seq_control.sv
// Directed-plus-random bench for seq_control with FIFO1/FIFO2/UART environment models.
module tb_seq_control;

  localparam int MAXB = 4;

  logic        clk_100 = 1'b0;
  logic        Reset = 1'b1;
  logic [7:0]  rx_byte = 8'h00;
  logic        rx_ready = 1'b0, auto_mode = 1'b0;
  logic        load_wr_ack = 1'b0, load_full = 1'b0, load_empty = 1'b1;
  logic        cap_empty = 1'b1, cap_rd_ack = 1'b0, tx_busy = 1'b0;
  logic        load_wr_en, shift_rd_en, cap_wr_en, cap_rd_en, tx_en, err;
  logic [15:0] load_count;
  logic [2:0]  state_o;
  logic [1:0]  err_code;

  seq_control #(.MAX_BYTES(MAXB), .TIMEOUT_CYC(100)) dut (
    .clk_100(clk_100), .Reset(Reset), .rx_byte(rx_byte), .rx_ready(rx_ready),
    .auto_mode(auto_mode), .load_wr_en(load_wr_en), .load_wr_ack(load_wr_ack),
    .load_full(load_full), .load_empty(load_empty), .shift_rd_en(shift_rd_en),
    .cap_wr_en(cap_wr_en), .cap_empty(cap_empty), .cap_rd_en(cap_rd_en),
    .cap_rd_ack(cap_rd_ack), .tx_busy(tx_busy), .tx_en(tx_en),
    .load_count(load_count), .state_o(state_o), .err(err), .err_code(err_code)
  );

  always #5 clk_100 = ~clk_100;

  int n_cmp = 0, n_bad = 0;
  // environment state
  int fifo1_words = 0, fifo2_words = 0, wr_age = 0, ack_delay = 0, tx_left = 0;
  bit wr_en_prev = 0, need_gate = 0, busy_rose = 0;
  // observed traffic
  int n_wr, wr_len, max_wr_len, n_shift_rd, n_cap_wr, n_cap_rd, n_tx, n_gate_bad;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic clear_counts();
    n_wr = 0; wr_len = 0; max_wr_len = 0; n_shift_rd = 0; n_cap_wr = 0;
    n_cap_rd = 0; n_tx = 0; n_gate_bad = 0;
  endtask

  // FIFO1 empty flag anticipates the pop being performed this cycle.
  task automatic drive_env();
    load_empty = (fifo1_words - (shift_rd_en ? 1 : 0)) <= 0;
    cap_empty  = (fifo2_words == 0);
    tx_busy    = (tx_left > 0);
    load_wr_ack = load_wr_en && (wr_age >= ack_delay);
  endtask

  task automatic step();
    bit push1, pop1, push2, pop2, start_tx, wr_now;
    if (load_wr_en && !wr_en_prev) n_wr++;
    wr_len = load_wr_en ? wr_len + 1 : 0;
    if (wr_len > max_wr_len) max_wr_len = wr_len;
    if (shift_rd_en) n_shift_rd++;
    if (cap_wr_en) n_cap_wr++;
    if (cap_rd_en) begin
      n_cap_rd++;
      if (need_gate || tx_busy) n_gate_bad++;
    end
    if (tx_busy && need_gate) busy_rose = 1;
    if (!tx_busy && busy_rose) begin need_gate = 0; busy_rose = 0; end
    if (tx_en) begin n_tx++; need_gate = 1; busy_rose = 0; end
    push1 = load_wr_en && load_wr_ack;
    pop1  = shift_rd_en && fifo1_words > 0;
    push2 = cap_wr_en;
    pop2  = cap_rd_en && fifo2_words > 0;
    start_tx = tx_en;
    wr_now = load_wr_en;
    @(posedge clk_100); #1;
    fifo1_words += (push1 ? 1 : 0) - (pop1 ? 1 : 0);
    fifo2_words += (push2 ? 1 : 0) - (pop2 ? 1 : 0);
    cap_rd_ack = pop2;
    if (start_tx) tx_left = $urandom_range(1, 3);
    else if (tx_left > 0) tx_left--;
    if (load_wr_en) begin
      if (wr_now) wr_age++;
      else begin wr_age = 0; ack_delay = $urandom_range(0, 1); end
    end else wr_age = 0;
    wr_en_prev = wr_now;
    drive_env();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte = b; rx_ready = 1'b1;
    step();
    rx_ready = 1'b0; rx_byte = 8'($urandom);
  endtask

  task automatic send_data(input int n);
    logic [7:0] b;
    for (int i = 0; i < n; i++) begin
      b = 8'($urandom_range(0, 253));
      send(b);
      idle($urandom_range(2, 5));
    end
  endtask

  task automatic wait_state(input logic [2:0] want, input int budget, input string tag);
    for (int i = 0; i < budget && state_o != want; i++) step();
    check(tag, 32'(state_o), 32'(want));
  endtask

  task automatic flush_env();
    fifo1_words = 0; fifo2_words = 0; load_full = 1'b0;
    drive_env();
  endtask

  initial begin
    int cyc, n_bytes, exp_acc;
    clear_counts();
    drive_env();
    idle(3);
    Reset = 1'b0;
    check("reset_state", 32'(state_o), 0);
    check("reset_load_count", 32'(load_count), 0);
    check("reset_err", 32'(err), 0);
    check("reset_err_code", 32'(err_code), 0);
    check("reset_strobes", 32'({load_wr_en, shift_rd_en, cap_wr_en, cap_rd_en, tx_en}), 0);

    send(8'h55);
    check("idle_ignores_byte", 32'(state_o), 0);

    // LOAD three bytes, manual mode
    clear_counts(); auto_mode = 1'b0;
    send(8'hFF);
    check("load_entry_count", 32'(load_count), 0);
    send_data(3);
    send(8'hFE);
    wait_state(3'd0, 10, "a_back_idle");
    check("a_writes", 32'(n_wr), 3);
    check("a_load_count", 32'(load_count), 3);
    check("a_pulse_len_le2", 32'(max_wr_len <= 2), 1);
    check("a_fifo1_words", 32'(fifo1_words), 3);

    // full auto chain LOAD -> SHIFT -> READ
    flush_env(); clear_counts(); auto_mode = 1'b1;
    send(8'hFF);
    send_data(4);
    send(8'hFE);
    wait_state(3'd3, 60, "b_reach_read");
    check("b_shift_reads", 32'(n_shift_rd), 4);
    check("b_cap_writes", 32'(n_cap_wr), 4);
    wait_state(3'd0, 300, "b_back_idle");
    check("b_writes", 32'(n_wr), 4);
    check("b_cap_reads", 32'(n_cap_rd), 4);
    check("b_tx_starts", 32'(n_tx), 4);
    check("b_tx_gating", 32'(n_gate_bad), 0);
    check("b_fifo2_drained", 32'(fifo2_words), 0);

    // overflow past MAX_BYTES
    flush_env(); clear_counts(); auto_mode = 1'b0;
    n_bytes = MAXB + 1;
    exp_acc = (n_bytes < MAXB) ? n_bytes : MAXB;
    send(8'hFF);
    send_data(n_bytes);
    wait_state(3'd4, 5, "c_error_state");
    check("c_writes", 32'(n_wr), 32'(exp_acc));
    check("c_load_count", 32'(load_count), 32'(exp_acc));
    check("c_err", 32'(err), 1);
    check("c_err_code", 32'(err_code), 1);
    check("c_error_strobes", 32'({load_wr_en, shift_rd_en, cap_wr_en, cap_rd_en, tx_en}), 0);
    send(8'hFF);
    check("c_stays_error", 32'(state_o), 4);
    send(8'h00);
    check("c_clr_state", 32'(state_o), 0);
    check("c_clr_err", 32'(err), 0);
    check("c_clr_err_code", 32'(err_code), 0);

    // FIFO1 full on the second data byte
    flush_env(); clear_counts();
    send(8'hFF);
    send_data(1);
    load_full = 1'b1;
    send_data(1);
    check("d_error_state", 32'(state_o), 4);
    check("d_err_code", 32'(err_code), 3);
    check("d_writes", 32'(n_wr), 1);
    load_full = 1'b0;
    send(8'h00);

    // two back-to-back bytes use the holding register
    flush_env(); clear_counts();
    send(8'hFF);
    send(8'($urandom_range(0, 253)));
    send(8'($urandom_range(0, 253)));
    idle(8);
    send(8'hFE);
    wait_state(3'd0, 10, "e_back_idle");
    check("e_writes", 32'(n_wr), 2);
    check("e_load_count", 32'(load_count), 2);

    // third back-to-back byte finds the holding register occupied
    flush_env(); clear_counts();
    send(8'hFF);
    send(8'h11); send(8'h22); send(8'h33);
    check("f_error_state", 32'(state_o), 4);
    check("f_err_code", 32'(err_code), 1);
    send(8'h00);

    // LOAD with no further bytes
    flush_env(); clear_counts();
    send(8'hFF);
`ifdef SEQ_TIMEOUT_EN
    cyc = 0;
    while (state_o != 3'd4 && cyc < 300) begin step(); cyc++; end
    check("g_timeout_cycles_ok", 32'(cyc >= 98 && cyc <= 102), 1);
    check("g_err_code", 32'(err_code), 2);
    send(8'h00);
`else
    cyc = 0;
    idle(300);
    check("g_still_load", 32'(state_o), 1);
    check("g_no_err", 32'(err), 0);
    send(8'hFE);
    wait_state(3'd0, 10, "g_back_idle");
`endif

    // SHIFT with FIFO1 already empty
    flush_env(); clear_counts(); auto_mode = 1'b0;
    send(8'h7F);
    wait_state(3'd0, 5, "h_back_idle");
    check("h_no_reads", 32'(n_shift_rd), 0);
    check("h_no_cap_writes", 32'(n_cap_wr), 0);

    // reset while a read ack is in flight
    flush_env(); clear_counts();
    fifo2_words = 2; drive_env();
    send(8'h7E);
    cyc = 0;
    while (!cap_rd_ack && cyc < 10) begin step(); cyc++; end
    check("i_ack_seen", 32'(cap_rd_ack), 1);
    Reset = 1'b1;
    step();
    check("i_reset_state", 32'(state_o), 0);
    check("i_reset_outputs", 32'({load_wr_en, shift_rd_en, cap_wr_en, cap_rd_en, tx_en, err, err_code, load_count}), 0);
    Reset = 1'b0;
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_control.md
SEQ_CONTROL -- requirements
Module: seq_control

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- CMD_LOAD, 8'hFF, enter LOAD.
- CMD_SHIFT, 8'h7F, enter SHIFT.
- CMD_READ, 8'h7E, enter READ.
- CMD_END, 8'hFE, end LOAD.
- CMD_CLR, 8'h00, clear ERROR.
- MAX_BYTES, 256, LOAD byte limit (2..65535).
- TIMEOUT_CYC, 1000000, LOAD idle-cycle limit.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clk_100, in, 1, the single clock.
- Reset, in, 1, synchronous active-high reset.
- rx_byte, in, 8, UART byte; valid when rx_ready.
- rx_ready, in, 1, one-cycle strobe.
- auto_mode, in, 1, chain LOAD->SHIFT->READ.
- load_wr_en, out, 1, FIFO1 write strobe.
- load_wr_ack, in, 1, FIFO1 write accepted.
- load_full, in, 1, FIFO1 full.
- load_empty, in, 1, FIFO1 empty.
- shift_rd_en, out, 1, FIFO1 read enable.
- cap_wr_en, out, 1, FIFO2 write enable.
- cap_empty, in, 1, FIFO2 empty.
- cap_rd_en, out, 1, FIFO2 read strobe.
- cap_rd_ack, in, 1, FIFO2 data valid.
- tx_busy, in, 1, UART transmitting.
- tx_en, out, 1, UART start strobe.
- load_count, out, 16, bytes accepted in the current LOAD.
- state_o, out, 3, current state code.
- err, out, 1, sticky error.
- err_code, out, 2, 01 overflow, 10 timeout, 11 FIFO full.
REQ-003 The single clock is clk_100; Reset is synchronous and active-high.

Function
REQ-010 The state machine SHALL have the states IDLE=0, LOAD=1, SHIFT=2, READ=3 and ERROR=4.
REQ-011 IDLE: on rx_ready the block SHALL go to LOAD for CMD_LOAD, SHIFT for CMD_SHIFT and READ for CMD_READ; any other byte is ignored.
REQ-012 On entry to LOAD, load_count SHALL clear to 0.
REQ-013 LOAD: each rx_ready with a byte other than CMD_END SHALL produce exactly one load_wr_en pulse on the following cycle, and load_count SHALL increment.
REQ-014 The LOAD write pulse SHALL stay asserted until load_wr_ack is seen, but for no more than 2 cycles; no second write is issued while the first is outstanding.
REQ-015 LOAD + CMD_END: the next state SHALL be SHIFT if auto_mode=1, else IDLE.
REQ-016 LOAD data byte arriving while load_count==MAX_BYTES: the byte SHALL be dropped, err_code=01, next state ERROR.
REQ-017 LOAD data byte arriving while load_full=1: the byte SHALL be dropped, err_code=11, next state ERROR.
REQ-018 SHIFT: shift_rd_en and cap_wr_en SHALL both be asserted each cycle that load_empty=0; cap_wr_en is shift_rd_en delayed by one cycle, giving 1-cycle latency.
REQ-019 SHIFT exit: when load_empty=1, the block SHALL drain for one cycle with cap_wr_en high for the final word, then go to READ if auto_mode=1, else IDLE.
REQ-020 SHIFT with load_empty=1 on the entry cycle SHALL go straight to the exit with no strobes.
REQ-021 READ: with tx_busy=0, cap_empty=0 and no read outstanding, the block SHALL pulse cap_rd_en for 1 cycle.
REQ-022 READ: on cap_rd_ack, tx_en SHALL pulse for 1 cycle; the next cap_rd_en is held off until tx_busy has been seen rising and then falling again.
REQ-023 READ: with cap_empty=1, tx_busy=0 and nothing outstanding, the block SHALL go to IDLE.
REQ-024 ERROR: all strobes SHALL be 0; only rx_ready with CMD_CLR leaves ERROR, going to IDLE and clearing err and err_code.
REQ-025 rx_ready bytes in SHIFT and READ SHALL be ignored.
REQ-026 If rx_ready coincides with a pending LOAD write, the new byte SHALL be queued in a 1-entry holding register.
REQ-027 A further byte arriving while the holding register is full SHALL raise err_code=01 and go to ERROR.
REQ-028 The strobe outputs (load_wr_en, shift_rd_en, cap_wr_en, cap_rd_en, tx_en) SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-030 With Reset high at a clock edge, state SHALL be IDLE and every strobe, load_count, err and err_code SHALL be 0.
REQ-031 Reset SHALL take effect the next edge from any state, including mid-LOAD or mid-READ; any outstanding handshake is abandoned.

Configuration
REQ-040 With SEQ_TIMEOUT_EN defined, a counter SHALL reload on every rx_ready in LOAD.
REQ-041 With SEQ_TIMEOUT_EN defined, reaching TIMEOUT_CYC idle cycles in LOAD SHALL set err_code=10 and go to ERROR.
REQ-042 Without SEQ_TIMEOUT_EN, no counter logic SHALL exist, LOAD waits indefinitely, and err_code=10 is never produced.

Structure
REQ-050 Package seq_pkg SHALL hold the state enum (width 3), the err_code constants and the default command-byte constants.
REQ-051 The block SHALL contain one sub-module, seq_watchdog (loadable down-counter with expiry flag), instantiated only under SEQ_TIMEOUT_EN.

Verification
REQ-060 The bench SHALL cover these directed scenarios:
- FF, 3 data bytes, FE with auto_mode=0 -> 3 load_wr_en pulses, load_count=3, IDLE.
- FF, 4 bytes, FE with auto_mode=1, load_empty falling after 4 reads -> SHIFT with 4 cap_wr_en, then READ with 4 cap_rd_en/tx_en pairs each gated by a tx_busy cycle, then IDLE.
- MAX_BYTES=4, FF then 5 data bytes -> 4 writes, 5th dropped, err=1, err_code=01, ERROR; then 00 -> IDLE, err=0.
- load_full=1 on the 2nd data byte -> 1 write, err_code=11.
- SEQ_TIMEOUT_EN with TIMEOUT_CYC=100: FF and no further bytes -> ERROR with err_code=10 after 100 cycles.
- Reset asserted mid-READ with tx_en pending -> next cycle all outputs 0 and state_o=0.
